// File: rtl/cache_pkg.sv
// cache_pkg: shared geometry constants and controller state encoding for the
// direct-mapped cache datapath.
`default_nettype none

package cache_pkg;

  localparam int ADDR_W     = 15;
  localparam int TAG_W      = 3;
  localparam int INDEX_W    = 10;
  localparam int OFFSET_W   = 2;
  localparam int LINE_W     = 128;
  localparam int MEM_ADDR_W = 13;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOOKUP = 3'd1,
    S_MISS   = 3'd2,
    S_FILL   = 3'd3,
    S_DONE   = 3'd4
  } ctrl_state_t;

endpackage

`default_nettype wire

// File: rtl/cache_stats.sv
// cache_stats: per-run hit and access counters with synchronous clear.
// Instantiated by cache_access_ctrl only when CACHE_CTRL_STATS_EN is defined.
`default_nettype none

module cache_stats #(
  parameter int CNT_W = 14
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             inc_hit_i,
  input  logic             inc_acc_i,
  output logic [CNT_W-1:0] hit_count_o,
  output logic [CNT_W-1:0] access_count_o
);

  logic [CNT_W-1:0] hit_q;
  logic [CNT_W-1:0] acc_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hit_q <= '0;
      acc_q <= '0;
    end else if (clear_i) begin
      hit_q <= '0;
      acc_q <= '0;
    end else begin
      if (inc_hit_i) hit_q <= hit_q + CNT_W'(1);
      if (inc_acc_i) acc_q <= acc_q + CNT_W'(1);
    end
  end

  assign hit_count_o    = hit_q;
  assign access_count_o = acc_q;

endmodule

`default_nettype wire

// File: rtl/cache_access_ctrl.sv
// cache_access_ctrl: address sequencer / miss-fill controller for the direct-mapped cache.
// Optional macro CACHE_CTRL_STATS_EN exposes hit/access counters (tied to 0 otherwise).
`default_nettype none

module cache_access_ctrl #(
  parameter int NUM_ACCESS = 8192,
  parameter int ADDR_W     = cache_pkg::ADDR_W,
  parameter int CNT_W      = $clog2(NUM_ACCESS + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [ADDR_W-1:0] addr,
  input  logic              hit,
  output logic              mem_req,
  input  logic              mem_ack,
  output logic              fill_we,
  output logic              acc_valid,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  access_count
);

  import cache_pkg::*;

  ctrl_state_t       state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [CNT_W-1:0]  acc_cnt_q;
  logic              mem_req_q;
  logic              fill_we_q;
  logic              acc_valid_q;
  logic              busy_q;
  logic              done_q;

  logic [ADDR_W-1:0] addr_d;
  logic [CNT_W-1:0]  acc_cnt_d;
  logic              last_access;

  assign addr_d      = addr_q + ADDR_W'(1);
  assign acc_cnt_d   = acc_cnt_q + CNT_W'(1);
  assign last_access = (acc_cnt_d == CNT_W'(NUM_ACCESS));

  // A hit in LOOKUP and the FILL cycle both retire one access the same way.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      acc_cnt_q   <= '0;
      mem_req_q   <= 1'b0;
      fill_we_q   <= 1'b0;
      acc_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      fill_we_q   <= 1'b0;
      acc_valid_q <= 1'b0;
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_q   <= S_LOOKUP;
            addr_q    <= '0;
            acc_cnt_q <= '0;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
          end
        end
        S_LOOKUP, S_FILL: begin
          if (state_q == S_FILL || hit) begin
            acc_valid_q <= 1'b1;
            addr_q      <= addr_d;
            acc_cnt_q   <= acc_cnt_d;
            if (last_access) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_LOOKUP;
            end
          end else begin
            state_q   <= S_MISS;
            mem_req_q <= 1'b1;
          end
        end
        S_MISS: begin
          if (mem_ack) begin
            state_q   <= S_FILL;
            mem_req_q <= 1'b0;
            fill_we_q <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign addr      = addr_q;
  assign mem_req   = mem_req_q;
  assign fill_we   = fill_we_q;
  assign acc_valid = acc_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

`ifdef CACHE_CTRL_STATS_EN
  logic stat_clear;
  logic stat_inc_hit;
  logic stat_inc_acc;

  assign stat_clear   = ((state_q == S_IDLE) || (state_q == S_DONE)) && start;
  assign stat_inc_hit = (state_q == S_LOOKUP) && hit;
  assign stat_inc_acc = stat_inc_hit || (state_q == S_FILL);

  cache_stats #(
    .CNT_W (CNT_W)
  ) u_stats (
    .clk            (clk),
    .rst_n          (rst_n),
    .clear_i        (stat_clear),
    .inc_hit_i      (stat_inc_hit),
    .inc_acc_i      (stat_inc_acc),
    .hit_count_o    (hit_count),
    .access_count_o (access_count)
  );
`else
  assign hit_count    = '0;
  assign access_count = '0;
`endif

endmodule

`default_nettype wire

// File: doc/cache_access_ctrl.md
# cache_access_ctrl

Sequencing controller for the direct-mapped cache datapath: generates the 15-bit access address stream, stalls on a cache miss while a 128-bit line is fetched from main memory, pulses the cache line-fill write, and counts hits and accesses. It replaces the free-running address generator and ad-hoc negedge counters, and sits between the testbench/top level and the cache plus main-memory pair.

## Interface
- NUM_ACCESS, 8192: accesses per run; run ends after this many completed accesses
- ADDR_W, 15: byte/word address width (tag 3 + index 10 + offset 2)
- CNT_W, $clog2(NUM_ACCESS+1): hit/access counter width (14 for default)
- clk  in  1  system clock, all logic on posedge
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  begin a run; sampled in IDLE or DONE only
- addr  out  ADDR_W  registered address presented to the address decoder
- hit  in  1  cache hit for current addr, combinational from cache, valid same cycle
- mem_req  out  1  line-fetch request, level, held until acknowledged
- mem_ack  in  1  memory line valid; one-cycle pulse
- fill_we  out  1  one-cycle cache line write enable (tag+data at current index)
- acc_valid  out  1  one-cycle pulse per completed access
- busy  out  1  high in LOOKUP, MISS, FILL
- done  out  1  high in DONE
- hit_count  out  CNT_W  completed hits this run
- access_count  out  CNT_W  completed accesses this run

## Operation
- States: IDLE, LOOKUP, MISS, FILL, DONE.
- Reset (rst_n low at posedge): state IDLE; addr=0, mem_req=0, fill_we=0, acc_valid=0, busy=0, done=0, hit_count=0, access_count=0. Reset mid-miss drops mem_req at that edge; a later mem_ack is ignored.
- IDLE: start=1 -> LOOKUP; addr=0, counters cleared.
- LOOKUP, hit=1: acc_valid=1, hit_count+1, access_count+1, addr+1; if access_count+1==NUM_ACCESS -> DONE else stay LOOKUP.
- LOOKUP, hit=0: -> MISS, mem_req=1, addr held.
- MISS: mem_req held high; mem_ack=1 -> FILL, mem_req=0. mem_ack=0 -> stay (no timeout).
- FILL: fill_we=1 for exactly this cycle; counted as a miss: acc_valid=1, access_count+1, hit_count unchanged, addr+1; terminal check as in LOOKUP -> DONE or LOOKUP. No re-lookup of the filled address.
- DONE: done=1, counters and addr frozen; start=1 -> LOOKUP with addr=0 and counters cleared (same as IDLE).
- start ignored in LOOKUP/MISS/FILL. mem_ack outside MISS ignored.
- addr wraps 2^ADDR_W-1 -> 0 silently; counters never exceed NUM_ACCESS.

## Timing
- All outputs registered except none; state and outputs update on posedge only.
- Hit access: 1 cycle; back-to-back hits sustain 1 access/cycle.
- Miss access: LOOKUP 1 + MISS (W+1, W = cycles before mem_ack) + FILL 1 = W+3 cycles.
- mem_req rises the edge after miss detection; mem_ack may arrive in the first MISS cycle (W=0).
- done rises on the edge completing access NUM_ACCESS; run of all hits takes NUM_ACCESS cycles after start.

## Configuration
- CACHE_CTRL_STATS_EN defined: hit_count/access_count implemented as above.
- Not defined: both counter outputs tied to 0; termination uses an internal access counter that is still present. All other behaviour identical.

## Structure
- Shared package cache_pkg: ADDR_W, TAG_W=3, INDEX_W=10, OFFSET_W=2, LINE_W=128, MEM_ADDR_W=13, state enum ctrl_state_t.
- One sub-module cache_stats: hit/access counters with clear, inc_hit, inc_acc; instantiated only under CACHE_CTRL_STATS_EN.

## Test plan
- Reset then start, hit tied 1 -> done after 8192 cycles, hit_count=8192, access_count=8192, mem_req never high.
- hit tied 0, mem_ack 2 cycles after each mem_req -> each access 5 cycles, fill_we one pulse per access, hit_count=0, access_count=8192.
- NUM_ACCESS=4, hit pattern 0,1,1,0 with W=0 -> addr sequence 0,1,2,3, hit_count=2, access_count=4, done.
- rst_n low during MISS with mem_ack arriving next cycle -> mem_req=0 after reset edge, no fill_we, all counters 0, state IDLE.
- start asserted during LOOKUP ignored; start in DONE -> addr=0, counters 0, new run completes identically.
- Build without CACHE_CTRL_STATS_EN -> counters read 0, done timing unchanged versus first scenario.
